// File: rtl/pc_fetch_unit_if.sv
// Front-end fetch bus: decode-side next-PC selection in, instruction-memory
// request and PC status out. "master" is the fetch unit, "slave" its surroundings.
interface pc_fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       pc_src;
    logic             pc_src_valid;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] jreg_target;
    logic             halt;
    logic             stall;
    logic             imem_ready;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus2;
    logic             fetch_valid;
    logic             halted;
    logic             err;

    modport master (
        input  pc_src, pc_src_valid, branch_target, jump_target, jreg_target,
               halt, stall, imem_ready,
        output imem_req, imem_addr, pc, pc_plus2, fetch_valid, halted, err
    );

    modport slave (
        output pc_src, pc_src_valid, branch_target, jump_target, jreg_target,
               halt, stall, imem_ready,
        input  imem_req, imem_addr, pc, pc_plus2, fetch_valid, halted, err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Multi-cycle fetch/next-PC stage: FETCH waits on imem, DECIDE waits on the
// decoded next-PC select, HALTED is terminal until reset.
module pc_fetch_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    pc_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECIDE = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [2:0] SRC_PLUS2  = 3'b001;
    localparam logic [2:0] SRC_BRANCH = 3'b011;
    localparam logic [2:0] SRC_JUMP   = 3'b100;
    localparam logic [2:0] SRC_JREG   = 3'b010;

    state_t           state;
    logic [WIDTH-1:0] pc_q;
    logic             imem_req_q;
    logic             fetch_valid_q;
    logic             halted_q;
    logic             err_q;
    logic [WIDTH-1:0] pc_plus2;

    assign pc_plus2 = pc_q + WIDTH'(2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b1;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.imem_ready) begin
                        state         <= DECIDE;
                        imem_req_q    <= 1'b0;
                        fetch_valid_q <= 1'b1;
                    end
                end
                DECIDE: begin
                    if (bus.pc_src_valid && !bus.stall) begin
                        // halt outranks an illegal select, so a HALT never flags err
                        if (bus.halt) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            case (bus.pc_src)
                                SRC_PLUS2: begin
                                    pc_q       <= pc_plus2;
                                    state      <= FETCH;
                                    imem_req_q <= 1'b1;
                                end
                                SRC_BRANCH: begin
                                    pc_q       <= bus.branch_target;
                                    state      <= FETCH;
                                    imem_req_q <= 1'b1;
                                end
                                SRC_JUMP: begin
                                    pc_q       <= bus.jump_target;
                                    state      <= FETCH;
                                    imem_req_q <= 1'b1;
                                end
                                SRC_JREG: begin
                                    pc_q       <= bus.jreg_target;
                                    state      <= FETCH;
                                    imem_req_q <= 1'b1;
                                end
                                default: begin
                                    state    <= HALTED;
                                    halted_q <= 1'b1;
                                    err_q    <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: ; // HALTED: frozen until reset
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc_plus2    = pc_plus2;
    assign bus.imem_req    = imem_req_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;
endmodule
